// File: rtl/alu_cntrl_pipe.sv
// alu_cntrl_pipe: registered, handshaked ALU control decoder.
//
// Decodes a function code into a unit select (out_fc2) and a per-unit sub-op
// (out_fc4) and flags illegal codes. The result is held in a single output
// register behind a valid/ready handshake. Unit 2 is multi-cycle, so a busy
// counter spaces out back-to-back unit-2 issues.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              drops the held op and blocks input for this cycle
//   in_valid/in_ready  input handshake carrying in_func
//   in_func            function code
//   out_valid/out_ready output handshake
//   out_fc2, out_fc4   unit select and sub-op of the held op
//   out_illegal        held op came from an illegal code
//   mc_busy            unit-2 busy counter is non-zero
//   illegal_cnt        saturating count of illegal ops handed downstream
module alu_cntrl_pipe #(
  parameter int unsigned FUNC_W    = 4,
  parameter int unsigned UNIT_W    = 2,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned MC_LAT    = 4,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FUNC_W-1:0]    in_func,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [UNIT_W-1:0]    out_fc2,
  output logic [OP_W-1:0]      out_fc4,
  output logic                 out_illegal,
  output logic                 mc_busy,
  output logic [ILL_CNT_W-1:0] illegal_cnt
);

  localparam int unsigned CntW = (MC_LAT < 1) ? 1 : $clog2(MC_LAT + 1);
  localparam logic [UNIT_W-1:0] UnitMc = UNIT_W'(2);

  logic [31:0]          func_ext;
  logic [UNIT_W-1:0]    dec_fc2;
  logic [OP_W-1:0]      dec_fc4;
  logic                 dec_ill;

  logic                 out_valid_q, out_valid_d;
  logic [UNIT_W-1:0]    out_fc2_q, out_fc2_d;
  logic [OP_W-1:0]      out_fc4_q, out_fc4_d;
  logic                 out_ill_q, out_ill_d;
  logic [CntW-1:0]      mc_cnt_q, mc_cnt_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic                 accept;
  logic                 out_hs;
  logic                 mc_block;

  assign func_ext = 32'(in_func);

  // Function code decode.
  always_comb begin
    dec_fc2 = '0;
    dec_fc4 = '0;
    dec_ill = 1'b0;
    if (func_ext <= 32'd5) begin
      dec_fc4 = OP_W'(func_ext);
    end else if (func_ext <= 32'd9) begin
      dec_fc4 = OP_W'(func_ext + 32'd2);
    end else if (func_ext <= 32'd11) begin
      dec_fc2 = UNIT_W'(1);
      dec_fc4 = OP_W'(func_ext - 32'd10);
    end else if (func_ext <= 32'd14) begin
      dec_fc2 = UnitMc;
      dec_fc4 = OP_W'(func_ext - 32'd12);
    end else begin
      dec_fc2 = '1;
      dec_ill = 1'b1;
    end
  end

  // A unit-2 op must wait while unit 2 is still busy, and also while another
  // unit-2 op sits in the output register (its counter load is still pending).
  assign mc_block = (dec_fc2 == UnitMc) &
                    ((mc_cnt_q != '0) | (out_valid_q & (out_fc2_q == UnitMc)));
  assign in_ready = ~flush & (~out_valid_q | out_ready) & ~mc_block;
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_fc2_d   = out_fc2_q;
    out_fc4_d   = out_fc4_q;
    out_ill_d   = out_ill_q;
    mc_cnt_d    = mc_cnt_q;
    ill_cnt_d   = ill_cnt_q;

    // accept cannot coincide with flush since in_ready is low during flush.
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_fc2_d   = dec_fc2;
      out_fc4_d   = dec_fc4;
      out_ill_d   = dec_ill;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

    // flush leaves the counter alone: the unit is already executing.
    if (out_hs && (out_fc2_q == UnitMc)) begin
      mc_cnt_d = CntW'(MC_LAT);
    end else if (mc_cnt_q != '0) begin
      mc_cnt_d = mc_cnt_q - CntW'(1);
    end

    if (out_hs && out_ill_q && (ill_cnt_q != '1)) begin
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_fc2_q   <= '0;
      out_fc4_q   <= '0;
      out_ill_q   <= 1'b0;
      mc_cnt_q    <= '0;
      ill_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_fc2_q   <= out_fc2_d;
      out_fc4_q   <= out_fc4_d;
      out_ill_q   <= out_ill_d;
      mc_cnt_q    <= mc_cnt_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_fc2     = out_fc2_q;
  assign out_fc4     = out_fc4_q;
  assign out_illegal = out_ill_q;
  assign mc_busy     = (mc_cnt_q != '0);
  assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_alu_cntrl_pipe.sv
// Bench for alu_cntrl_pipe: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the decoder stage.
module tb_alu_cntrl_pipe;

  localparam int McLat  = 4;
  localparam int IllMax = 3;  // ILL_CNT_W = 2

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_func;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_fc2;
  logic [3:0] out_fc4;
  logic       out_illegal;
  logic       mc_busy;
  logic [1:0] illegal_cnt;

  alu_cntrl_pipe #(
    .FUNC_W    (4),
    .UNIT_W    (2),
    .OP_W      (4),
    .MC_LAT    (McLat),
    .ILL_CNT_W (2)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_func     (in_func),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fc2     (out_fc2),
    .out_fc4     (out_fc4),
    .out_illegal (out_illegal),
    .mc_busy     (mc_busy),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: the op held downstream, remaining unit-2 busy cycles, and the
  // number of illegal ops delivered.
  bit m_valid;
  int m_fc2, m_fc4;
  bit m_ill;
  int m_busy;
  int m_illcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic ref_dec(input int f, output int fc2, output int fc4, output bit ill);
    ill = 1'b0;
    if (f < 6) begin
      fc2 = 0; fc4 = f;
    end else if (f < 10) begin
      fc2 = 0; fc4 = f + 2;
    end else if (f < 12) begin
      fc2 = 1; fc4 = f - 10;
    end else if (f < 15) begin
      fc2 = 2; fc4 = f - 12;
    end else begin
      fc2 = 3; fc4 = 0; ill = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_fc2 = 0; m_fc4 = 0; m_ill = 1'b0; m_busy = 0; m_illcnt = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check the registered
  // state and in_ready, then advance the model across the next rising edge.
  task automatic step(input logic v, input logic [3:0] f, input logic r, input logic fl);
    int  dfc2, dfc4;
    bit  dill, blk, rdy, hs, acc;
    @(negedge clk);
    in_valid  = v;
    in_func   = f;
    out_ready = r;
    flush     = fl;
    #1;
    ref_dec(int'(f), dfc2, dfc4, dill);
    blk = (dfc2 == 2) && (m_busy != 0 || (m_valid && m_fc2 == 2));
    rdy = !fl && (!m_valid || r) && !blk;
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, m_valid);
    check("out_fc2", out_fc2, m_fc2);
    check("out_fc4", out_fc4, m_fc4);
    check("out_illegal", out_illegal, m_ill);
    check("mc_busy", mc_busy, m_busy != 0);
    check("illegal_cnt", illegal_cnt, m_illcnt);
    hs  = m_valid && r;
    acc = v && rdy;
    if (hs && m_fc2 == 2) m_busy = McLat;
    else if (m_busy > 0) m_busy--;
    if (hs && m_ill && m_illcnt < IllMax) m_illcnt++;
    if (fl) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_fc2 = dfc2; m_fc4 = dfc4; m_ill = dill;
    end else if (hs) m_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int blocked;
    bit acc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_func = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Sweep every code; each accepted op appears on the next cycle.
    for (int f = 0; f < 16; f++) begin
      acc = 1'b0;
      for (int k = 0; k < 12 && !acc; k++) begin
        step(1'b1, 4'(f), 1'b1, 1'b0);
        acc = in_ready;
      end
      check("sweep_accept", in_ready, 1);
      step(1'b0, 4'd0, 1'b1, 1'b0);
      check("sweep_valid", out_valid, 1);
      case (f)
        6:  check("sweep6",  {out_illegal, out_fc2, out_fc4}, 7'b0_00_1000);
        9:  check("sweep9",  {out_illegal, out_fc2, out_fc4}, 7'b0_00_1011);
        11: check("sweep11", {out_illegal, out_fc2, out_fc4}, 7'b0_01_0001);
        14: check("sweep14", {out_illegal, out_fc2, out_fc4}, 7'b0_10_0010);
        15: check("sweep15", {out_illegal, out_fc2, out_fc4}, 7'b1_11_0000);
        default: ;
      endcase
    end
    repeat (6) step(1'b0, 4'd0, 1'b1, 1'b0);

    // Backpressure: held op stays put, then handshake and new accept share an edge.
    step(1'b1, 4'd7, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'd5, 1'b0, 1'b0);
      check("bp_hold_fc4", out_fc4, 4'b1001);
      check("bp_blocked", in_ready, 0);
    end
    step(1'b1, 4'd5, 1'b1, 1'b0);
    check("bp_release", in_ready, 1);
    repeat (6) step(1'b0, 4'd0, 1'b1, 1'b0);

    // Unit-2 spacing: 13 waits until the busy window from 12 has drained.
    step(1'b1, 4'd12, 1'b1, 1'b0);
    blocked = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 4'd13, 1'b1, 1'b0);
      if (in_ready) break;
      blocked++;
    end
    check("mc_spacing", blocked, 5);
    repeat (8) step(1'b0, 4'd0, 1'b1, 1'b0);

    // Non-unit-2 code during busy window, then reset in the middle of it.
    step(1'b1, 4'd12, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'd3, 1'b0, 1'b0);
    check("busy_other_unit", in_ready, 1);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("busy_op3", {out_fc2, out_fc4}, 6'b00_0011);
    @(posedge clk);
    #2;
    check("pre_rst_busy", mc_busy, 1);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {out_valid, out_fc2, out_fc4, out_illegal, mc_busy, illegal_cnt},
          11'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 4'd12, 1'b1, 1'b0);
    check("rst_accept12", in_ready, 1);
    repeat (8) step(1'b0, 4'd0, 1'b1, 1'b0);

    // Flushed illegal op is not counted; counter saturates at 3.
    step(1'b1, 4'd15, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("flush_ill_cnt", illegal_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd15, 1'b1, 1'b0);
      step(1'b0, 4'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("ill_sat", illegal_cnt, (i + 1 > IllMax) ? IllMax : i + 1);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end
    step(1'b0, 4'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
